// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small receive FIFO and a valid/ready byte output.
//   clk        : system clock, rising edge
//   reset_pin  : asynchronous reset, active low
//   rx         : raw serial input, idle high, asynchronous to clk
//   m_data     : byte at FIFO head (registered)
//   m_valid    : FIFO non-empty (registered)
//   m_ready    : consumer accepts m_data when m_valid && m_ready
//   fifo_level : number of stored bytes, 0..FIFO_DEPTH
//   busy       : receiver FSM not idle
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   overrun    : 1-cycle pulse, received byte dropped because FIFO full
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 72,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_pin,
  input  logic                          rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [2:0]       idx,     idx_n;
  logic [7:0]       shreg,   shreg_n;
  logic [7:0]       mem      [FIFO_DEPTH];
  logic [7:0]       mem_n    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr,  rd_n;
  logic [PTR_W-1:0] wr_ptr,  wr_n;
  logic [LVL_W-1:0] level_n;
  logic [7:0]       m_data_n;
  logic             m_valid_n;
  logic             busy_n;
  logic             ferr_n;
  logic             ovr_n;
  logic             push_c;
  logic             push_ok_c;
  logic             pop_c;
  logic             full_c;

  // State and datapath registers; sync flops reset high so release is not a start edge.
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      mem        <= '{default: '0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      mem        <= mem_n;
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_n;
      fifo_level <= level_n;
      m_data     <= m_data_n;
      m_valid    <= m_valid_n;
      busy       <= busy_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
    end
  end

  // Receiver next-state: all sampling points land at mid-bit via the down-counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    push_c  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          cnt_n   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_n = ST_DATA;
            cnt_n   = FULL_LOAD;
            idx_n   = 3'd0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = FULL_LOAD;
          if (idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Return to idle at mid-stop so the next start edge is not missed.
        if (cnt == '0) begin
          if (rx_s) begin
            push_c  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FIFO next-state; a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    mem_n     = mem;
    rd_n      = rd_ptr;
    wr_n      = wr_ptr;
    level_n   = fifo_level;
    ovr_n     = 1'b0;
    pop_c     = m_valid && m_ready;
    full_c    = (fifo_level == DEPTH_LVL);
    push_ok_c = push_c && (!full_c || pop_c);

    if (pop_c) begin
      rd_n = rd_ptr + PTR_W'(1);
    end
    if (push_ok_c) begin
      mem_n[wr_ptr] = shreg;
      wr_n          = wr_ptr + PTR_W'(1);
    end
    if (push_c && !push_ok_c) begin
      ovr_n = 1'b1;
    end

    if (push_ok_c && !pop_c) begin
      level_n = fifo_level + LVL_W'(1);
    end else if (!push_ok_c && pop_c) begin
      level_n = fifo_level - LVL_W'(1);
    end

    m_data_n  = mem_n[rd_n];
    m_valid_n = (level_n != '0);
    busy_n    = (state_n != ST_IDLE);
  end

endmodule
